ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave SRAM that serves as backing memory for the data cache's line fills, write-backs and write-through stores. It sits directly downstream of the cache's AHB master port, on a single-slave bus with no interconnect. It decodes pipelined address/data phases and inserts a programmable number of wait states per beat. It performs byte, halfword and word accesses and returns the two-cycle AHB ERROR response for illegal accesses.

## Interface
- MEM_WORDS, 1024: number of 32-bit words; power of two.
- WAIT_NONSEQ, 2: wait states inserted on a NONSEQ beat, 0..15.
- WAIT_SEQ, 0: wait states inserted on a SEQ beat, 0..15.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HBURST  in  3  burst type; informational only.
- HMASTLOCK  in  1  ignored.
- HPROT  in  4  ignored.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; larger values are illegal.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  1 = write.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer done or slave ready; the master also samples it for the address phase.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase accepted at an edge where HREADY=1, HSEL=1 and HTRANS is NONSEQ or SEQ.
  - The slave latches addr, size, write and seq.
  - IDLE or BUSY transfers, or HSEL=0, get a zero-wait OKAY.
- Legality checks:
  - HSIZE>2 is illegal.
  - HSIZE=1 with HADDR[0]=1 is illegal.
  - HSIZE=2 with HADDR[1:0]≠0 is illegal.
  - HADDR[31:2] ≥ MEM_WORDS is illegal.
- Word index is HADDR[$clog2(MEM_WORDS)+1:2].
- Byte lanes:
  - byte: lane HADDR[1:0].
  - half: lanes {HADDR[1],0} and {HADDR[1],1}.
  - word: all four lanes.
- FSM states:
  - IDLE: HREADY=1, HRESP=0.
  - WAIT: HREADY=0, wait counter loaded with WAIT_NONSEQ or WAIT_SEQ.
  - DATA: HREADY=1, HRESP=0; the beat completes.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- Transitions:
  - Legal accept with wait count 0 → DATA.
  - Legal accept with wait count >0 → WAIT; the counter decrements each cycle, and at 1 → DATA.
  - Illegal accept → ERR1 → ERR2.
  - From DATA or ERR2, the next state follows whatever is accepted at the same edge (back-to-back pipelining); if nothing is accepted → IDLE.
- Writes:
  - HWDATA lanes are committed to memory at the edge that ends DATA (HREADY=1).
  - No memory update on an ERROR transfer.
- Reads:
  - HRDATA is loaded from memory at the edge entering DATA and held until the next read enters DATA.
  - HRDATA is full 32-bit word data regardless of HSIZE.
- Write-to-read forwarding: if a write completes at the same edge that a read to the same word enters DATA (zero-wait read), HRDATA returns the merged new word.
- HBURST is not used for address generation; every beat's HADDR is taken from the bus. INCR4 and WRAP4 beats are therefore handled identically.
- Reset mid-transfer: the FSM returns to IDLE, and any pending write is discarded (memory unchanged). Memory contents are not reset.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter 0.
- A NONSEQ read accepted at edge N completes at edge N+1+WAIT_NONSEQ, with HREADY low for WAIT_NONSEQ cycles.
- A SEQ beat completes WAIT_SEQ+1 edges after acceptance.
- A zero-wait 4-beat burst completes in 4 consecutive cycles.
- An ERROR response lasts exactly 2 cycles; the following address phase is sampled at the ERR2 edge.
- Address signals are ignored while HREADY=0.

## Test plan
- Read after reset: with WAIT_NONSEQ=2, NONSEQ word write of 0xDEADBEEF to 0x40, then NONSEQ read of 0x40 → HREADY low for 2 cycles, then HRDATA=0xDEADBEEF with HRESP=0.
- Cache line fill: with WAIT_NONSEQ=2 and WAIT_SEQ=0, WRAP4 read at 0x18, 0x1C, 0x10, 0x14 → 2 waits on the first beat, then 3 back-to-back beats returning the stored words in wrap order.
- Byte lanes: word 0x11223344 at 0x80; byte write 0xAA to 0x81; half write 0xBBCC to 0x82 → read of 0x80 returns 0xBBCCAA44.
- Errors:
  - Word access at 0x6 → HRESP=1 for 2 cycles, HREADY=0 then 1.
  - Address 0x1000 with MEM_WORDS=1024 → same 2-cycle ERROR response.
  - Memory is unchanged after both.
- Forwarding: with WAIT_NONSEQ=0, a write of 0x5 to 0x20 immediately followed by a read of 0x20 → HRDATA=0x5 in the very next cycle.
- Reset mid-operation: assert reset during the WAIT state of a write of 0x77 to 0x30 → HREADY=1 and HRESP=0 immediately; a later read of 0x30 returns the old value.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle between the cache master port and the SRAM slave
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR response
module ahb_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_NONSEQ = 2,
  parameter int WAIT_SEQ    = 0
) (
  input  logic           clk,
  input  logic           reset,
  ahb_sram_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_next;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_lanes;
  logic          r_write;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_ready;
  logic          w_accept;
  logic          w_legal;
  logic [3:0]    w_lanes;
  logic [3:0]    w_wait_load;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_commit;
  logic          w_rd_load;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  assign w_ready     = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept    = w_ready && bus.HSEL && bus.HTRANS[1];
  assign w_idx       = bus.HADDR[AW+1:2];
  assign w_wait_load = bus.HTRANS[0] ? 4'(WAIT_SEQ) : 4'(WAIT_NONSEQ);
  assign w_commit    = (r_state == S_DATA) && r_write && !reset;
  assign w_unused    = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT};

  always_comb begin
    w_legal = 1'b1;
    w_lanes = 4'b1111;
    case (bus.HSIZE)
      3'd0: w_lanes = 4'b0001 << bus.HADDR[1:0];
      3'd1: begin
        w_lanes = bus.HADDR[1] ? 4'b1100 : 4'b0011;
        if (bus.HADDR[0]) w_legal = 1'b0;
      end
      3'd2: if (bus.HADDR[1:0] != 2'b00) w_legal = 1'b0;
      default: w_legal = 1'b0;
    endcase
    if ({2'b00, bus.HADDR[31:2]} >= 32'(MEM_WORDS)) w_legal = 1'b0;
  end

  // DATA and ERR2 both end with HREADY=1, so they accept the next address phase like IDLE
  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    case (r_state)
      S_WAIT: begin
        w_wait_next = r_wait_cnt - 4'd1;
        if (r_wait_cnt == 4'd1) w_next = S_DATA;
      end
      S_ERR1: w_next = S_ERR2;
      default: begin
        w_next      = S_IDLE;
        w_wait_next = 4'd0;
        if (w_accept) begin
          if (!w_legal) begin
            w_next = S_ERR1;
          end else if (w_wait_load == 4'd0) begin
            w_next = S_DATA;
          end else begin
            w_next      = S_WAIT;
            w_wait_next = w_wait_load;
          end
        end
      end
    endcase
  end

  assign w_rd_load = (w_next == S_DATA) && ((r_state == S_WAIT) ? !r_write : !bus.HWRITE);
  assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : w_idx;

  // A zero-wait read can enter DATA on the same edge a write to its word commits
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_commit && (r_idx == w_rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (r_lanes[i]) w_rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_lanes    <= 4'd0;
      r_write    <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_lanes <= w_lanes;
        r_write <= bus.HWRITE;
      end
      if (w_rd_load) r_rdata <= w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_lanes[i]) r_mem[r_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADY = w_ready;
  assign bus.HRESP  = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign bus.HRDATA = r_rdata;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef struct {
    int          id;
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_waits;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [32];
  int   nvec = 0;
  vec_t sb_q [$];

  ahb_sram_slave_if bus_a();
  ahb_sram_slave_if bus_b();

  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_NONSEQ(2), .WAIT_SEQ(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_NONSEQ(0), .WAIT_SEQ(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic [1:0] trans, input logic write, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic err, input int waits,
                     input logic chk, input logic [31:0] rdata);
    vecs[nvec] = '{nvec, sel, trans, write, size, addr, wdata, err, waits, chk, rdata};
    nvec++;
  endtask

  task automatic drive_addr(input int k, input int hi);
    if (k < hi) begin
      bus_a.HSEL   = vecs[k].sel;
      bus_a.HTRANS = vecs[k].trans;
      bus_a.HWRITE = vecs[k].write;
      bus_a.HSIZE  = vecs[k].size;
      bus_a.HADDR  = vecs[k].addr;
    end else begin
      bus_a.HSEL   = 1'b1;
      bus_a.HTRANS = T_IDLE;
      bus_a.HWRITE = 1'b0;
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int   ai;
    int   waits;
    int   cyc;
    bit   busy;
    vec_t cur;
    ai = lo; waits = 0; cyc = 0; busy = 0;
    drive_addr(ai, hi);
    while ((ai < hi || busy) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus_a.HREADY) begin
        if (busy) begin
          cur = sb_q.pop_front();
          check($sformatf("v%0d_resp", cur.id), 32'(bus_a.HRESP), 32'(cur.exp_err));
          check($sformatf("v%0d_waits", cur.id), 32'(waits), 32'(cur.exp_waits));
          if (cur.chk_rd) check($sformatf("v%0d_rdata", cur.id), bus_a.HRDATA, cur.exp_rdata);
        end
        busy = 0;
        if (ai < hi) begin
          if (vecs[ai].sel && vecs[ai].trans[1]) begin
            sb_q.push_back(vecs[ai]);
            busy = 1;
          end
          ai++;
        end
        waits = 0;
        @(posedge clk); #1;
        bus_a.HWDATA = busy ? sb_q[0].wdata : 32'h0;
        drive_addr(ai, hi);
      end else begin
        waits++;
        if (busy) check($sformatf("v%0d_wait_resp", sb_q[0].id), 32'(bus_a.HRESP), 32'(sb_q[0].exp_err));
        if (waits > 20) begin
          check("wait_budget", 32'(waits), 32'd20);
          busy = 0;
          ai = hi;
          sb_q.delete();
        end
        @(posedge clk); #1;
      end
    end
    if (busy || ai < hi) check("run_vecs_budget", 32'(cyc), 32'd400);
  endtask

  task automatic b_addr(input logic [1:0] trans, input logic write, input logic [31:0] addr);
    bus_b.HTRANS = trans;
    bus_b.HWRITE = write;
    bus_b.HSIZE  = 3'd2;
    bus_b.HADDR  = addr;
  endtask

  initial begin
    bus_a.HSEL = 1'b1; bus_a.HADDR = 32'h0; bus_a.HBURST = 3'b010; bus_a.HMASTLOCK = 1'b0;
    bus_a.HPROT = 4'b0011; bus_a.HSIZE = 3'd2; bus_a.HTRANS = T_IDLE; bus_a.HWDATA = 32'h0;
    bus_a.HWRITE = 1'b0;
    bus_b.HSEL = 1'b1; bus_b.HADDR = 32'h0; bus_b.HBURST = 3'b000; bus_b.HMASTLOCK = 1'b0;
    bus_b.HPROT = 4'b0011; bus_b.HSIZE = 3'd2; bus_b.HTRANS = T_IDLE; bus_b.HWDATA = 32'h0;
    bus_b.HWRITE = 1'b0;

    // Phase 1 vectors (0..27)
    add(1, T_NSEQ, 1, 3'd2, 32'h40,   32'hDEADBEEF, 0, 2, 0, 32'h0);
    add(0, T_NSEQ, 1, 3'd2, 32'h40,   32'h00000000, 0, 0, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd2, 32'h40,   32'h0,        0, 2, 1, 32'hDEADBEEF);
    add(1, T_NSEQ, 1, 3'd2, 32'h10,   32'hA0A00010, 0, 2, 0, 32'h0);
    add(1, T_SEQ,  1, 3'd2, 32'h14,   32'hA1A10014, 0, 0, 0, 32'h0);
    add(1, T_SEQ,  1, 3'd2, 32'h18,   32'hA2A20018, 0, 0, 0, 32'h0);
    add(1, T_SEQ,  1, 3'd2, 32'h1C,   32'hA3A3001C, 0, 0, 0, 32'h0);
    add(1, T_IDLE, 0, 3'd2, 32'h0,    32'h0,        0, 0, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd2, 32'h18,   32'h0,        0, 2, 1, 32'hA2A20018);
    add(1, T_SEQ,  0, 3'd2, 32'h1C,   32'h0,        0, 0, 1, 32'hA3A3001C);
    add(1, T_SEQ,  0, 3'd2, 32'h10,   32'h0,        0, 0, 1, 32'hA0A00010);
    add(1, T_SEQ,  0, 3'd2, 32'h14,   32'h0,        0, 0, 1, 32'hA1A10014);
    add(1, T_NSEQ, 1, 3'd2, 32'h80,   32'h11223344, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 1, 3'd0, 32'h81,   32'h0000AA00, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 1, 3'd1, 32'h82,   32'hBBCC0000, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd2, 32'h80,   32'h0,        0, 2, 1, 32'hBBCCAA44);
    add(1, T_NSEQ, 0, 3'd0, 32'h83,   32'h0,        0, 2, 1, 32'hBBCCAA44);
    add(1, T_NSEQ, 1, 3'd2, 32'h4,    32'h12345678, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 1, 3'd2, 32'h6,    32'hFFFFFFFF, 1, 1, 0, 32'h0);
    add(1, T_NSEQ, 1, 3'd2, 32'h0,    32'hCAFEF00D, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 1, 3'd2, 32'h1000, 32'hFFFFFFFF, 1, 1, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd1, 32'h5,    32'h0,        1, 1, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd3, 32'h0,    32'h0,        1, 1, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd2, 32'h4,    32'h0,        0, 2, 1, 32'h12345678);
    add(1, T_NSEQ, 0, 3'd2, 32'h0,    32'h0,        0, 2, 1, 32'hCAFEF00D);
    add(1, T_NSEQ, 1, 3'd2, 32'hFFC,  32'h0BADCAFE, 0, 2, 0, 32'h0);
    add(1, T_NSEQ, 0, 3'd2, 32'hFFC,  32'h0,        0, 2, 1, 32'h0BADCAFE);
    add(1, T_NSEQ, 1, 3'd2, 32'h30,   32'h00000011, 0, 2, 0, 32'h0);
    // Phase 2 vectors (28..29), after the mid-transfer reset
    add(1, T_NSEQ, 0, 3'd2, 32'h30,   32'h0,        0, 2, 1, 32'h00000011);
    add(1, T_NSEQ, 0, 3'd2, 32'h40,   32'h0,        0, 2, 1, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_hready", 32'(bus_a.HREADY), 32'd1);
    check("rst_a_hresp",  32'(bus_a.HRESP),  32'd0);
    check("rst_a_hrdata", bus_a.HRDATA,      32'h0);
    check("rst_b_hready", 32'(bus_b.HREADY), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run_vecs(0, 28);

    // Reset asserted while a write to 0x30 sits in WAIT
    @(posedge clk); #1;
    bus_a.HSEL = 1'b1; bus_a.HTRANS = T_NSEQ; bus_a.HWRITE = 1'b1; bus_a.HSIZE = 3'd2; bus_a.HADDR = 32'h30;
    @(posedge clk); #1;
    bus_a.HWDATA = 32'h77; bus_a.HTRANS = T_IDLE; bus_a.HWRITE = 1'b0;
    @(negedge clk);
    check("mid_wait_hready", 32'(bus_a.HREADY), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_hready", 32'(bus_a.HREADY), 32'd1);
    check("mid_rst_hresp",  32'(bus_a.HRESP),  32'd0);
    check("mid_rst_hrdata", bus_a.HRDATA,      32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_vecs(28, 30);

    // Forwarding on the zero-wait instance
    @(posedge clk); #1;
    b_addr(T_NSEQ, 1'b1, 32'h20);
    @(posedge clk); #1;
    bus_b.HWDATA = 32'hFFFFFFFF;
    b_addr(T_IDLE, 1'b0, 32'h0);
    @(posedge clk); #1;
    b_addr(T_NSEQ, 1'b1, 32'h20);
    @(negedge clk);
    check("fwd_wr_accept_hready", 32'(bus_b.HREADY), 32'd1);
    @(posedge clk); #1;
    bus_b.HWDATA = 32'h5;
    b_addr(T_NSEQ, 1'b0, 32'h20);
    @(negedge clk);
    check("fwd_wr_data_hready", 32'(bus_b.HREADY), 32'd1);
    @(posedge clk); #1;
    b_addr(T_IDLE, 1'b0, 32'h0);
    @(negedge clk);
    check("fwd_hrdata", bus_b.HRDATA, 32'h5);
    check("fwd_hresp",  32'(bus_b.HRESP), 32'd0);
    check("fwd_hready", 32'(bus_b.HREADY), 32'd1);
    @(posedge clk); #1;
    b_addr(T_NSEQ, 1'b0, 32'h20);
    @(posedge clk); #1;
    b_addr(T_IDLE, 1'b0, 32'h0);
    @(negedge clk);
    check("fwd_mem_hrdata", bus_b.HRDATA, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
